vga_sync_monitor: RTL

Receive-side checker and decoder for the 800x600@60 VGA timing used on the display path. It samples HS, VS and blank as produced by the VGA timing generator and rebuilds the line and frame counters from the sync edges. It locks onto the timing, regenerates row/col/pixel_valid for downstream capture logic, and flags any line, frame, sync-width or blank-window violation. It sits on the 40 MHz display clock beside the generator, or on the far side of a board link.

---
 rtl/vga_sync_monitor.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor
// Receive-side checker for VGA-style HS/VS/blank timing. Registers the sync
// inputs, rebuilds line/frame counters from the sync edges, and locks once a
// full frame has been checked. While locked it regenerates row/col/pixel_valid
// and flags line, frame, sync-width and blank-window violations.
module vga_sync_monitor #(
  parameter int H_TOTAL      = 1056,
  parameter int H_SYNC       = 128,
  parameter int H_DISP_START = 216,
  parameter int H_DISP       = 800,
  parameter int V_TOTAL      = 628,
  parameter int V_SYNC       = 4,
  parameter int V_DISP_START = 27,
  parameter int V_DISP       = 600
) (
  input  logic       clock_40MHz,
  input  logic       reset,
  input  logic       HS,
  input  logic       VS,
  input  logic       blank,
  output logic [9:0] row,
  output logic [9:0] col,
  output logic       pixel_valid,
  output logic       line_start,
  output logic       frame_start,
  output logic       locked,
  output logic       h_err,
  output logic       v_err,
  output logic       blank_err
);

  // Timing constants sized to the counter arithmetic they are compared with.
  localparam logic [11:0] HTOT_C = 12'(H_TOTAL);
  localparam logic [11:0] VTOT_C = 12'(V_TOTAL);
  localparam logic [10:0] HSYN_C = 11'(H_SYNC);
  localparam logic [10:0] VSYN_C = 11'(V_SYNC);
  localparam logic [10:0] HDS_C  = 11'(H_DISP_START);
  localparam logic [10:0] HDE_C  = 11'(H_DISP_START + H_DISP - 1);
  localparam logic [10:0] VDS_C  = 11'(V_DISP_START);
  localparam logic [10:0] VDE_C  = 11'(V_DISP_START + V_DISP - 1);
  localparam logic [10:0] CNT_MAX_C = 11'h7FF;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Input stage and previous-value registers
  logic hs_q, vs_q, blank_q, hs_prev_q, vs_prev_q;
  // Counters and FSM
  logic [10:0] h_count_q, h_count_d, v_count_q, v_count_d;
  state_t      state_q, state_d;
  // Registered outputs
  logic [9:0]  row_q, row_d, col_q, col_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic        line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic        locked_q, locked_d;
  logic        h_err_q, h_err_d, v_err_q, v_err_d, blank_err_q, blank_err_d;

  // Edge and check terms
  logic        hs_fall_s, hs_rise_s, vs_fall_s, vs_rise_s;
  logic [10:0] h_inc_s, v_inc_s;
  logic        h_fail_s, v_fail_s, chk_en_s, lock_s, in_win_s;
  logic [10:0] h_diff_s, v_diff_s;

  assign hs_fall_s = ~hs_q & hs_prev_q;
  assign hs_rise_s = hs_q & ~hs_prev_q;
  assign vs_fall_s = ~vs_q & vs_prev_q;
  assign vs_rise_s = vs_q & ~vs_prev_q;

  assign h_inc_s = (h_count_q == CNT_MAX_C) ? CNT_MAX_C : h_count_q + 11'd1;
  assign v_inc_s = (v_count_q == CNT_MAX_C) ? CNT_MAX_C : v_count_q + 11'd1;

  // Register the raw sync/blank inputs and keep one cycle of history for edges.
  always_ff @(posedge clock_40MHz or posedge reset) begin
    if (reset) begin
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      blank_q   <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      hs_q      <= HS;
      vs_q      <= VS;
      blank_q   <= blank;
      hs_prev_q <= hs_q;
      vs_prev_q <= vs_q;
    end
  end

  // Current-cycle counter values; these track the generator position of the
  // sample now held in the input stage.
  always_comb begin
    h_count_d = h_inc_s;
    v_count_d = v_count_q;
    if ((state_q == SEARCH) && vs_fall_s) begin
      h_count_d = 11'd0;
      v_count_d = 11'd0;
    end else if (hs_fall_s) begin
      h_count_d = 11'd0;
      if (vs_fall_s) begin
        v_count_d = 11'd0;
      end else begin
        v_count_d = v_inc_s;
      end
    end else begin
      h_count_d = h_inc_s;
      v_count_d = v_count_q;
    end
  end

  // Line/frame length and sync width checks; a VS edge off the line start is
  // also a frame error.
  assign h_fail_s = (hs_fall_s && (({1'b0, h_count_q} + 12'd1) != HTOT_C)) ||
                    (hs_rise_s && (h_count_d != HSYN_C));
  assign v_fail_s = (vs_fall_s && (({1'b0, v_count_q} + 12'd1) != VTOT_C)) ||
                    (vs_rise_s && (v_count_d != VSYN_C)) ||
                    (vs_fall_s && !hs_fall_s);
  assign chk_en_s = (state_q != SEARCH);

  // Lock FSM next state; a failing check always wins over a passing frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH: begin
        if (vs_fall_s) begin
          state_d = SYNC;
        end else begin
          state_d = SEARCH;
        end
      end
      SYNC: begin
        if (h_fail_s || v_fail_s) begin
          state_d = SEARCH;
        end else if (vs_fall_s) begin
          state_d = LOCKED;
        end else begin
          state_d = SYNC;
        end
      end
      LOCKED: begin
        if (h_fail_s || v_fail_s) begin
          state_d = SEARCH;
        end else begin
          state_d = LOCKED;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // Counter and FSM state registers.
  always_ff @(posedge clock_40MHz or posedge reset) begin
    if (reset) begin
      h_count_q <= 11'd0;
      v_count_q <= 11'd0;
      state_q   <= SEARCH;
    end else begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
      state_q   <= state_d;
    end
  end

  // Output gating follows the state being entered so locked, error pulses and
  // the regenerated pixel stream change together.
  assign lock_s   = (state_d == LOCKED);
  assign in_win_s = (h_count_d >= HDS_C) && (h_count_d <= HDE_C) &&
                    (v_count_d >= VDS_C) && (v_count_d <= VDE_C);
  assign h_diff_s = h_count_d - HDS_C;
  assign v_diff_s = v_count_d - VDS_C;

  // Next values for all registered outputs.
  always_comb begin
    pixel_valid_d = 1'b0;
    row_d         = 10'd0;
    col_d         = 10'd0;
    if (lock_s && in_win_s) begin
      pixel_valid_d = 1'b1;
      row_d         = v_diff_s[9:0];
      col_d         = h_diff_s[9:0];
    end else begin
      pixel_valid_d = 1'b0;
      row_d         = 10'd0;
      col_d         = 10'd0;
    end
    line_start_d  = lock_s & hs_fall_s;
    frame_start_d = lock_s & vs_fall_s;
    locked_d      = lock_s;
    h_err_d       = chk_en_s & h_fail_s;
    v_err_d       = chk_en_s & v_fail_s;
    blank_err_d   = lock_s & (blank_q != ~in_win_s);
  end

  // Output registers.
  always_ff @(posedge clock_40MHz or posedge reset) begin
    if (reset) begin
      row_q         <= 10'd0;
      col_q         <= 10'd0;
      pixel_valid_q <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      h_err_q       <= 1'b0;
      v_err_q       <= 1'b0;
      blank_err_q   <= 1'b0;
    end else begin
      row_q         <= row_d;
      col_q         <= col_d;
      pixel_valid_q <= pixel_valid_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      h_err_q       <= h_err_d;
      v_err_q       <= v_err_d;
      blank_err_q   <= blank_err_d;
    end
  end

  assign row         = row_q;
  assign col         = col_q;
  assign pixel_valid = pixel_valid_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign h_err       = h_err_q;
  assign v_err       = v_err_q;
  assign blank_err   = blank_err_q;

endmodule
